// File: rtl/imem_rsp.sv
// imem_rsp: instruction-memory responder at the far end of the fetch handshake.
// Accepted PCs go through a one-deep SRAM read stage into a small response FIFO
// and come back as {pc, inst, err} in request order. A flush or reset drops the
// in-flight read and every buffered entry.
module imem_rsp #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   input  logic                  i_flush,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_req_pc,
   output logic                  o_mem_en,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [ADDR_WIDTH-1:0] o_rsp_pc,
   output logic [DATA_WIDTH-1:0] o_rsp_inst,
   output logic                  o_rsp_err
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W:0]   OCC_LIM = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   // Pointer increment with explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_LAST) begin
         nxt = '0;
      end else begin
         nxt = ptr + PTR_W'(1);
      end
      return nxt;
   endfunction

   // Read stage: the request whose SRAM data arrives this cycle.
   logic                  rd_vld_r;
   logic [ADDR_WIDTH-1:0] rd_pc_r;
   logic                  rd_err_r;

   // Response FIFO storage and control.
   logic [ADDR_WIDTH-1:0] fifo_pc_r   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_inst_r [FIFO_DEPTH];
   logic                  fifo_err_r  [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;

   logic [CNT_W:0]        occ_s;
   logic                  accept_s;
   logic                  misalign_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  rsp_vld_s;
   logic [DATA_WIDTH-1:0] push_inst_s;

   // Handshake decode. Ready counts the in-flight read as occupied so a push
   // always has a free slot; consumer pops never feed back into ready.
   always_comb begin
      occ_s       = {1'b0, count_r} + {{CNT_W{1'b0}}, rd_vld_r};
      misalign_s  = (i_req_pc[1:0] != 2'b00);
      o_req_ready = 1'b0;
      if (!i_sys_rst && !i_flush && (occ_s < OCC_LIM)) begin
         o_req_ready = 1'b1;
      end else begin
         o_req_ready = 1'b0;
      end
      accept_s    = i_req_valid && o_req_ready;
      o_mem_en    = accept_s && !misalign_s;
      o_mem_addr  = '0;
      if (accept_s) begin
         o_mem_addr = i_req_pc;
      end else begin
         o_mem_addr = '0;
      end
      push_s      = rd_vld_r && !i_flush && !i_sys_rst;
      push_inst_s = '0;
      if (rd_err_r) begin
         push_inst_s = '0;
      end else begin
         push_inst_s = i_mem_rdata;
      end
   end

   // Response head: zeroed whenever nothing is presented.
   always_comb begin
      rsp_vld_s   = (count_r != '0) && !i_sys_rst;
      o_rsp_valid = rsp_vld_s;
      o_rsp_pc    = '0;
      o_rsp_inst  = '0;
      o_rsp_err   = 1'b0;
      if (rsp_vld_s) begin
         o_rsp_pc   = fifo_pc_r[rd_ptr_r];
         o_rsp_inst = fifo_inst_r[rd_ptr_r];
         o_rsp_err  = fifo_err_r[rd_ptr_r];
      end else begin
         o_rsp_pc   = '0;
         o_rsp_inst = '0;
         o_rsp_err  = 1'b0;
      end
      pop_s = rsp_vld_s && i_rsp_ready && !i_flush;
   end

   // Read stage and FIFO control: reset, then flush, then normal operation.
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         rd_vld_r <= 1'b0;
         rd_pc_r  <= '0;
         rd_err_r <= 1'b0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (i_flush) begin
         rd_vld_r <= 1'b0;
         count_r  <= '0;
         rd_ptr_r <= wr_ptr_r;
      end else begin
         rd_vld_r <= accept_s;
         if (accept_s) begin
            rd_pc_r  <= i_req_pc;
            rd_err_r <= misalign_s;
         end
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO payload write; contents need no reset because count gates visibility.
   always_ff @(posedge i_sys_clk) begin
      if (push_s) begin
         fifo_pc_r[wr_ptr_r]   <= rd_pc_r;
         fifo_inst_r[wr_ptr_r] <= push_inst_s;
         fifo_err_r[wr_ptr_r]  <= rd_err_r;
      end
   end

endmodule

// File: tb/tb_imem_rsp.sv
// tb_imem_rsp: randomized bench for imem_rsp with a queue-based reference model.
// The driver issues requests; a monitor keeps an in-order queue of accepted
// fetches (with accept cycle) and compares every presented response against it.
module tb_imem_rsp;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        i_sys_rst;
   logic        i_flush;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [31:0] i_req_pc;
   logic        o_mem_en;
   logic [31:0] o_mem_addr;
   logic [31:0] i_mem_rdata;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_pc;
   logic [31:0] o_rsp_inst;
   logic        o_rsp_err;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
      int          acc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          acc_cnt = 0;
   bit          rand_rdy = 1'b0;
   logic        en_cap = 1'b0;
   logic [31:0] addr_cap = 32'h0;

   always #5 clk = ~clk;

   imem_rsp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
      .i_sys_clk   (clk),
      .i_sys_rst   (i_sys_rst),
      .i_flush     (i_flush),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_pc    (i_req_pc),
      .o_mem_en    (o_mem_en),
      .o_mem_addr  (o_mem_addr),
      .i_mem_rdata (i_mem_rdata),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_pc    (o_rsp_pc),
      .o_rsp_inst  (o_rsp_inst),
      .o_rsp_err   (o_rsp_err)
   );

   // SRAM contents: 0x8000_0000 holds 0x13 (nop), other words are address-derived.
   function automatic logic [31:0] sram_word(input logic [31:0] a);
      return a ^ 32'h8000_0013;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // SRAM model: data for a cycle-N read appears during cycle N+1; otherwise junk.
   always begin
      @(posedge clk);
      #1;
      if (en_cap) i_mem_rdata = sram_word(addr_cap);
      else        i_mem_rdata = $urandom;
   end

   // Monitor and scoreboard, sampled mid-cycle when all inputs are stable.
   always @(negedge clk) begin
      exp_t e;
      bit   exp_vld;
      cyc++;
      en_cap   = o_mem_en;
      addr_cap = o_mem_addr;
      if (i_sys_rst) begin
         sb_q.delete();
         check("rst_req_ready", 64'(o_req_ready), 64'd0);
         check("rst_mem", 64'({o_mem_en, o_mem_addr}), 64'd0);
         check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
         check("rst_rsp_bus", 64'({o_rsp_err, o_rsp_pc | o_rsp_inst}), 64'd0);
      end else if (i_flush) begin
         check("flush_req_ready", 64'(o_req_ready), 64'd0);
         check("flush_mem_en", 64'(o_mem_en), 64'd0);
         sb_q.delete();
      end else begin
         exp_vld = (sb_q.size() > 0) && (sb_q[0].acc + 2 <= cyc);
         check("rsp_valid", 64'(o_rsp_valid), 64'(exp_vld));
         check("req_ready", 64'(o_req_ready), 64'(sb_q.size() < DEPTH));
         if (o_rsp_valid && exp_vld) begin
            check("rsp_pc", 64'(o_rsp_pc), 64'(sb_q[0].pc));
            check("rsp_inst", 64'(o_rsp_inst), 64'(sb_q[0].inst));
            check("rsp_err", 64'(o_rsp_err), 64'(sb_q[0].err));
            if (i_rsp_ready) void'(sb_q.pop_front());
         end else if (!o_rsp_valid) begin
            check("idle_rsp_bus", 64'({o_rsp_err, o_rsp_pc | o_rsp_inst}), 64'd0);
         end
         if (i_req_valid && o_req_ready) begin
            e.pc   = i_req_pc;
            e.err  = (i_req_pc[1:0] != 2'b00);
            e.inst = e.err ? 32'h0 : sram_word(i_req_pc);
            e.acc  = cyc;
            sb_q.push_back(e);
            acc_cnt++;
            check("mem_en", 64'(o_mem_en), 64'(!e.err));
            check("mem_addr", 64'(o_mem_addr), 64'(i_req_pc));
         end else begin
            check("mem_idle", 64'({o_mem_en, o_mem_addr}), 64'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_rdy) i_rsp_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      i_req_valid = 1'b0;
      i_req_pc    = 32'h0;
      repeat (n) step();
   endtask

   // Present one request and hold it until accepted (bounded).
   task automatic send(input logic [31:0] pc);
      bit acc = 1'b0;
      i_req_valid = 1'b1;
      i_req_pc    = pc;
      for (int t = 0; t < 64 && !acc; t++) begin
         @(negedge clk);
         acc = o_req_ready;
         step();
      end
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout pc 0x%08h: accepted 0 required 1", pc);
      end
   endtask

   task automatic drain();
      rand_rdy    = 1'b0;
      i_rsp_ready = 1'b1;
      i_req_valid = 1'b0;
      for (int t = 0; t < 40 && sb_q.size() != 0; t++) step();
      check("drain_empty", 64'(sb_q.size()), 64'd0);
      step();
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      logic [31:0] pc;
      i_sys_rst   = 1'b1;
      i_flush     = 1'b0;
      i_req_valid = 1'b0;
      i_req_pc    = 32'h0;
      i_rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      i_sys_rst = 1'b0;
      idle(2);

      // Single aligned fetch.
      send(32'h8000_0000);
      idle(4);

      // Back-to-back stream, consumer always ready.
      for (int i = 0; i < 8; i++) send(32'h8000_0000 + 32'(4 * i));
      idle(4);

      // Consumer stalled: exactly DEPTH accepts, then resume.
      i_rsp_ready = 1'b0;
      a0 = acc_cnt;
      for (int i = 0; i < 4; i++) send(32'h8000_1000 + 32'(4 * i));
      i_req_valid = 1'b1;
      i_req_pc    = 32'h8000_1010;
      repeat (5) step();
      check("stall_accepts", 64'(acc_cnt - a0), 64'd4);
      i_rsp_ready = 1'b1;
      send(32'h8000_1010);
      idle(6);

      // Misaligned fetch between aligned neighbours.
      send(32'h8000_0200);
      send(32'h8000_0202);
      send(32'h8000_0204);
      idle(5);

      // Flush with 3 buffered + 1 in flight.
      i_rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(32'h8000_2000 + 32'(4 * i));
      i_req_valid = 1'b0;
      i_flush     = 1'b1;
      step();
      i_flush = 1'b0;
      step();
      i_rsp_ready = 1'b1;
      send(32'h8000_0100);
      idle(4);

      // Reset with the FIFO partly full, then pointer wrap with random consumer.
      i_rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(32'h8000_3000 + 32'(4 * i));
      i_req_valid = 1'b0;
      i_sys_rst   = 1'b1;
      step();
      i_sys_rst = 1'b0;
      step();
      rand_rdy = 1'b1;
      for (int i = 0; i < 10; i++) send(32'h8000_4000 + 32'(4 * i));
      drain();

      // Random mix of aligned/misaligned fetches, gaps and flushes.
      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 11);
         if (r == 0) begin
            i_req_valid = 1'b0;
            i_flush     = 1'b1;
            step();
            i_flush = 1'b0;
         end else if (r < 3) begin
            idle($urandom_range(1, 3));
         end else begin
            pc = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
            if ($urandom_range(0, 5) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            send(pc);
         end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
